// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary bitstream decoder.
// Result scaling maps a window count onto the INWD-bit binary range.
package unary_pkg;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} udec_state_t;

   localparam int INWD_DEF = 8;
   localparam int INWD_MAX = 32;
   localparam int FIN_W    = 17;

   // Returns {sat, data}; data is right-aligned in the low INWD bits.
   function automatic logic [INWD_MAX:0] scale_to_inwd(input logic [FIN_W-1:0] fin,
                                                       input int winlog,
                                                       input int inwd);
      logic [INWD_MAX:0]   w_ones;
      logic [INWD_MAX-1:0] w_data;
      logic                w_sat;
      w_ones = ((INWD_MAX+1)'(1) << inwd) - (INWD_MAX+1)'(1);
      w_sat  = (fin == (FIN_W'(1) << winlog));
      if (w_sat)
         w_data = w_ones[INWD_MAX-1:0];
      else if (winlog >= inwd)
         w_data = INWD_MAX'(fin >> (winlog - inwd));
      else
         w_data = INWD_MAX'(fin) << (inwd - winlog);
      return {w_sat, w_data};
   endfunction

endpackage

// File: rtl/unary_win_ctr.sv
// Window counter: counts ones and enabled cycles over a 2^WINLOG window.
// oFin folds in the current bit so the closing edge sees the complete count.
module unary_win_ctr
   import unary_pkg::*;
#(
   parameter int WINLOG = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iClr,
   input  logic              iEn,
   input  logic              iBit,
   output logic [WINLOG:0]   oOnesCnt,
   output logic [WINLOG-1:0] oCycCnt,
   output logic              oLast,
   output logic [WINLOG:0]   oFin
);

   logic [WINLOG:0]   r_ones;
   logic [WINLOG-1:0] r_cyc;

   always_ff @(posedge clk) begin
      if (rst || iClr) begin
         r_ones <= '0;
         r_cyc  <= '0;
      end else if (iEn) begin
         r_ones <= r_ones + (WINLOG+1)'(iBit);
         r_cyc  <= r_cyc + WINLOG'(1);
      end
   end

   assign oOnesCnt = r_ones;
   assign oCycCnt  = r_cyc;
   assign oLast    = iEn & (&r_cyc);
   assign oFin     = r_ones + (WINLOG+1)'(iBit);

endmodule

// File: rtl/unary_stream_decoder.sv
// Decodes a unary bitstream into a scaled binary value over a 2^WINLOG enabled-cycle window.
// Result is presented in HOLD with valid/ready; a start during acceptance chains windows with no bubble.
module unary_stream_decoder
   import unary_pkg::*;
#(
   parameter int INWD   = INWD_DEF,
   parameter int WINLOG = INWD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iStart,
   input  logic            iEn,
   input  logic            iBit,
   output logic [INWD-1:0] oData,
   output logic            oVal,
   input  logic            iReady,
   output logic            oSat,
   output logic            oBusy
);

   udec_state_t       r_state, w_next;
   logic              w_clr, w_cnt_en, w_last, w_done;
   logic [WINLOG:0]   w_fin, w_ones_cnt;
   logic [WINLOG-1:0] w_cyc_cnt;
   logic [INWD_MAX:0] w_scaled;
   logic [INWD-1:0]   r_data;
   logic              r_sat;
   logic              w_unused;

   unary_win_ctr #(.WINLOG(WINLOG)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .iClr     (w_clr),
      .iEn      (w_cnt_en),
      .iBit     (iBit),
      .oOnesCnt (w_ones_cnt),
      .oCycCnt  (w_cyc_cnt),
      .oLast    (w_last),
      .oFin     (w_fin)
   );

   assign w_scaled = scale_to_inwd(FIN_W'(w_fin), WINLOG, INWD);
   assign w_unused = ^{w_scaled[INWD_MAX-1:INWD], w_ones_cnt, w_cyc_cnt};

   // A start in ACC wins over the closing edge: the partial window is dropped.
   always_comb begin
      w_next   = r_state;
      w_clr    = 1'b0;
      w_cnt_en = 1'b0;
      w_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (iStart) begin
               w_clr  = 1'b1;
               w_next = ACC;
            end
         end
         ACC: begin
            if (iStart) begin
               w_clr = 1'b1;
            end else begin
               w_cnt_en = iEn;
               if (w_last) begin
                  w_done = 1'b1;
                  w_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (iReady) begin
               if (iStart) begin
                  w_clr  = 1'b1;
                  w_next = ACC;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_done) begin
            r_data <= w_scaled[INWD-1:0];
            r_sat  <= w_scaled[INWD_MAX];
         end
      end
   end

   assign oData = r_data;
   assign oSat  = r_sat;
   assign oVal  = (r_state == HOLD);
   assign oBusy = (r_state != IDLE);

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Randomized bench for unary_stream_decoder against a count-and-scale reference model.
module tb_unary_stream_decoder;

   localparam int INWD   = 8;
   localparam int WINLOG = 8;
   localparam int WIN    = 1 << WINLOG;

   logic            clk = 1'b0;
   logic            rst, iStart, iEn, iBit, iReady;
   logic [INWD-1:0] oData;
   logic            oVal, oSat, oBusy;

   int n_chk  = 0;
   int n_pass = 0;
   int early;
   int ones;

   unary_stream_decoder #(.INWD(INWD), .WINLOG(WINLOG)) dut (
      .clk    (clk),
      .rst    (rst),
      .iStart (iStart),
      .iEn    (iEn),
      .iBit   (iBit),
      .oData  (oData),
      .oVal   (oVal),
      .iReady (iReady),
      .oSat   (oSat),
      .oBusy  (oBusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Fraction of ones in the window mapped to 0..2^INWD, full window pinned to all ones.
   function automatic int model_data(input int n_ones);
      if (n_ones == WIN) return (1 << INWD) - 1;
      return (n_ones * (1 << INWD)) / WIN;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_win();
      iStart = 1'b1;
      iEn    = 1'($urandom % 2);
      iBit   = 1'($urandom % 2);
      tick();
      iStart = 1'b0;
      iEn    = 1'b0;
      iBit   = 1'b0;
   endtask

   // mode: 0 alt 1,0  1 ones  2 zeros  3 random  4 every 4th  5 ones but first
   // gap:  0 none  1 every 3rd cycle off  2 random
   task automatic feed(input int n, input int mode, input int gap, output int n_ones);
      int  k   = 0;
      int  cyc = 0;
      logic en, b;
      n_ones = 0;
      early  = 0;
      while (k < n) begin
         case (gap)
            1:       en = (cyc % 3 != 2);
            2:       en = ($urandom % 4 != 0);
            default: en = 1'b1;
         endcase
         case (mode)
            0:       b = (k % 2 == 0);
            1:       b = 1'b1;
            2:       b = 1'b0;
            4:       b = (k % 4 == 0);
            5:       b = (k != 0);
            default: b = 1'($urandom % 2);
         endcase
         iEn  = en;
         iBit = en ? b : 1'($urandom % 2);
         if (en) begin
            k++;
            n_ones += int'(b);
         end
         tick();
         cyc++;
         if (k < n && oVal) early = 1;
      end
      iEn  = 1'b0;
      iBit = 1'b0;
   endtask

   task automatic check_result(input string tag, input int n_ones);
      chk({tag, "_early_val"}, early, 0);
      chk({tag, "_val"}, int'(oVal), 1);
      chk({tag, "_data"}, int'(oData), model_data(n_ones));
      chk({tag, "_sat"}, int'(oSat), int'(n_ones == WIN));
      chk({tag, "_busy"}, int'(oBusy), 1);
   endtask

   task automatic accept(input string tag);
      iReady = 1'b1;
      tick();
      iReady = 1'b0;
      chk({tag, "_acc_val"}, int'(oVal), 0);
      chk({tag, "_acc_busy"}, int'(oBusy), 0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_val"}, int'(oVal), 0);
      chk({tag, "_data"}, int'(oData), 0);
      chk({tag, "_sat"}, int'(oSat), 0);
      chk({tag, "_busy"}, int'(oBusy), 0);
   endtask

   initial begin
      rst = 1'b1; iStart = 1'b0; iEn = 1'b0; iBit = 1'b0; iReady = 1'b0;
      tick();
      tick();
      check_reset("reset");
      rst = 1'b0;

      start_win(); feed(WIN, 0, 0, ones); check_result("alt", ones); accept("alt");
      start_win(); feed(WIN, 1, 0, ones); check_result("ones", ones); accept("ones");
      start_win(); feed(WIN, 2, 0, ones); check_result("zeros", ones); accept("zeros");
      start_win(); feed(WIN, 5, 0, ones); check_result("ones_m1", ones); accept("ones_m1");
      start_win(); feed(WIN, 4, 1, ones); check_result("gaps", ones); accept("gaps");

      // Stall in HOLD with an ignored start, then chained accept+start.
      start_win(); feed(WIN, 3, 0, ones); check_result("stall", ones);
      for (int i = 0; i < 10; i++) begin
         iStart = (i == 4);
         iEn    = 1'b1;
         iBit   = 1'($urandom % 2);
         tick();
      end
      iStart = 1'b0; iEn = 1'b0;
      chk("stall_hold_val", int'(oVal), 1);
      chk("stall_hold_data", int'(oData), model_data(ones));
      iReady = 1'b1; iStart = 1'b1;
      tick();
      iReady = 1'b0; iStart = 1'b0;
      chk("b2b_val", int'(oVal), 0);
      chk("b2b_busy", int'(oBusy), 1);
      feed(WIN, 3, 0, ones); check_result("b2b", ones); accept("b2b");

      // Restart mid-window.
      start_win(); feed(100, 3, 0, ones);
      chk("abort_part_val", early, 0);
      start_win(); feed(WIN, 3, 0, ones); check_result("abort", ones); accept("abort");

      // Reset mid-window and in HOLD.
      start_win(); feed(50, 3, 0, ones);
      rst = 1'b1; tick(); rst = 1'b0;
      check_reset("rst_acc");
      start_win(); feed(WIN, 1, 0, ones); check_result("pre_rst", ones);
      rst = 1'b1; tick(); rst = 1'b0;
      check_reset("rst_hold");
      start_win(); feed(WIN, 0, 0, ones); check_result("post_rst", ones); accept("post_rst");

      for (int r = 0; r < 4; r++) begin
         start_win(); feed(WIN, 3, 2, ones); check_result("rand", ones); accept("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
